// File: rtl/ball_pkg.sv
// Shared types, geometry defaults and the per-axis bounce step
// used by ball_motion and its vblank detector.
package ball_pkg;

  typedef logic [10:0] coord_t;

  typedef enum logic [1:0] {
    WAIT,
    MOVE_X,
    MOVE_Y,
    COMMIT
  } ball_state_t;

  localparam int unsigned DEF_WIDTH  = 800;
  localparam int unsigned DEF_HEIGHT = 600;
  localparam int unsigned DEF_RADIUS = 17;
  localparam int unsigned DEF_STEP   = 2;
  localparam int unsigned DEF_X_INIT = 400;
  localparam int unsigned DEF_Y_INIT = 300;

  typedef struct packed {
    coord_t pos;
    logic   dir;
    logic   flip;
  } axis_t;

  // Down-going test compares against lo+step so p-step never wraps.
  function automatic axis_t axis_next(
    input coord_t p,
    input logic   d,
    input coord_t step,
    input coord_t lo,
    input coord_t hi
  );
    axis_t r;
    r.pos  = p;
    r.dir  = d;
    r.flip = 1'b0;
    if (d) begin
      if (p + step >= hi) begin
        r.pos  = hi;
        r.dir  = 1'b0;
        r.flip = 1'b1;
      end else begin
        r.pos = p + step;
      end
    end else begin
      if (p <= lo + step) begin
        r.pos  = lo;
        r.dir  = 1'b1;
        r.flip = 1'b1;
      end else begin
        r.pos = p - step;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ball_motion_vblank_detect.sv
// Detects the HEIGHT-1 -> HEIGHT line transition and registers
// a one-cycle frame_tick; det is the unregistered strobe.
module vblank_detect
  import ball_pkg::*;
#(
  parameter int unsigned HEIGHT = DEF_HEIGHT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] v_count,
  output logic        det,
  output logic        frame_tick
);

  localparam coord_t VB_LINE  = coord_t'(HEIGHT);
  localparam coord_t PRE_LINE = coord_t'(HEIGHT - 1);

  coord_t v_prev_q, v_prev_d;
  logic   tick_q, tick_d;

  always_comb begin
    v_prev_d = v_count;
    det      = (v_count == VB_LINE) && (v_prev_q == PRE_LINE);
    tick_d   = det;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_prev_q <= '0;
      tick_q   <= 1'b0;
    end else begin
      v_prev_q <= v_prev_d;
      tick_q   <= tick_d;
    end
  end

  assign frame_tick = tick_q;

endmodule

// File: rtl/ball_motion.sv
// Bouncing-object position generator, updated once per vblank.
// Define BALL_Y_MOTION_EN to let y move; otherwise y is fixed.
module ball_motion
  import ball_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned HEIGHT = DEF_HEIGHT,
  parameter int unsigned RADIUS = DEF_RADIUS,
  parameter int unsigned STEP   = DEF_STEP,
  parameter int unsigned X_INIT = DEF_X_INIT,
  parameter int unsigned Y_INIT = DEF_Y_INIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] h_count,
  input  logic [10:0] v_count,
  input  logic        run,
  output logic [10:0] x_pos,
  output logic [10:0] y_pos,
  output logic        frame_tick,
  output logic        bounce
);

  localparam coord_t XMIN  = coord_t'(RADIUS);
  localparam coord_t XMAX  = coord_t'(WIDTH - 1 - RADIUS);
  localparam coord_t STP   = coord_t'(STEP);
  localparam coord_t XI    = coord_t'(X_INIT);
  localparam coord_t YI    = coord_t'(Y_INIT);

  logic unused_h;
  assign unused_h = ^h_count;

  logic det;

  vblank_detect #(
    .HEIGHT(HEIGHT)
  ) u_vb (
    .clk       (clk),
    .rst       (rst),
    .v_count   (v_count),
    .det       (det),
    .frame_tick(frame_tick)
  );

  ball_state_t state_q, state_d;
  coord_t      x_q, x_d, nx_q, nx_d;
  logic        dx_q, dx_d, ndx_q, ndx_d;
  logic        fx_q, fx_d;
  logic        bounce_q, bounce_d;
  axis_t       ax_x;

`ifdef BALL_Y_MOTION_EN
  localparam coord_t YMIN = coord_t'(RADIUS);
  localparam coord_t YMAX = coord_t'(HEIGHT - 1 - RADIUS);
  coord_t y_q, y_d, ny_q, ny_d;
  logic   dy_q, dy_d, ndy_q, ndy_d;
  logic   fy_q, fy_d;
  logic   run_q, run_d;
  axis_t  ax_y;
`endif

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    dx_d     = dx_q;
    nx_d     = nx_q;
    ndx_d    = ndx_q;
    fx_d     = fx_q;
    bounce_d = 1'b0;
    ax_x     = axis_next(x_q, dx_q, STP, XMIN, XMAX);
`ifdef BALL_Y_MOTION_EN
    y_d      = y_q;
    dy_d     = dy_q;
    ny_d     = ny_q;
    ndy_d    = ndy_q;
    fy_d     = fy_q;
    run_d    = run_q;
    ax_y     = axis_next(y_q, dy_q, STP, YMIN, YMAX);
`endif
    unique case (state_q)
      WAIT: begin
        if (det) state_d = MOVE_X;
      end
      MOVE_X: begin
        state_d = MOVE_Y;
`ifdef BALL_Y_MOTION_EN
        run_d   = run;
`endif
        if (run) begin
          nx_d  = ax_x.pos;
          ndx_d = ax_x.dir;
          fx_d  = ax_x.flip;
        end else begin
          nx_d  = x_q;
          ndx_d = dx_q;
          fx_d  = 1'b0;
        end
      end
      MOVE_Y: begin
        state_d = COMMIT;
`ifdef BALL_Y_MOTION_EN
        if (run_q) begin
          ny_d  = ax_y.pos;
          ndy_d = ax_y.dir;
          fy_d  = ax_y.flip;
        end else begin
          ny_d  = y_q;
          ndy_d = dy_q;
          fy_d  = 1'b0;
        end
`endif
      end
      COMMIT: begin
        state_d  = WAIT;
        x_d      = nx_q;
        dx_d     = ndx_q;
`ifdef BALL_Y_MOTION_EN
        y_d      = ny_q;
        dy_d     = ndy_q;
        bounce_d = fx_q | fy_q;
`else
        bounce_d = fx_q;
`endif
      end
      default: state_d = WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WAIT;
      x_q      <= XI;
      dx_q     <= 1'b1;
      nx_q     <= XI;
      ndx_q    <= 1'b1;
      fx_q     <= 1'b0;
      bounce_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      dx_q     <= dx_d;
      nx_q     <= nx_d;
      ndx_q    <= ndx_d;
      fx_q     <= fx_d;
      bounce_q <= bounce_d;
    end
  end

`ifdef BALL_Y_MOTION_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q   <= YI;
      dy_q  <= 1'b1;
      ny_q  <= YI;
      ndy_q <= 1'b1;
      fy_q  <= 1'b0;
      run_q <= 1'b0;
    end else begin
      y_q   <= y_d;
      dy_q  <= dy_d;
      ny_q  <= ny_d;
      ndy_q <= ndy_d;
      fy_q  <= fy_d;
      run_q <= run_d;
    end
  end

  assign y_pos = y_q;
`else
  assign y_pos = YI;
`endif

  assign x_pos  = x_q;
  assign bounce = bounce_q;

endmodule

// File: tb/tb_ball_motion.sv
// Directed-vector bench for ball_motion with default geometry.
// Y expectations follow BALL_Y_MOTION_EN.
module tb_ball_motion;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] h_count = '0;
  logic [10:0] v_count = '0;
  logic        run = 1'b1;
  logic [10:0] x_pos, y_pos;
  logic        frame_tick, bounce;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ball_motion dut (
    .clk       (clk),
    .rst       (rst),
    .h_count   (h_count),
    .v_count   (v_count),
    .run       (run),
    .x_pos     (x_pos),
    .y_pos     (y_pos),
    .frame_tick(frame_tick),
    .bounce    (bounce)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    v_count = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One genuine 599->600 transition; samples tick in cycle 1
  // and position/bounce in cycle 4.
  task automatic do_frame(output logic ft, output int x,
                          output int y, output logic b);
    @(negedge clk);
    v_count = 11'd599;
    @(negedge clk);
    v_count = 11'd600;
    @(negedge clk);
    ft = frame_tick;
    v_count = 11'd0;
    repeat (3) @(negedge clk);
    x = int'(x_pos);
    y = int'(y_pos);
    b = bounce;
  endtask

  logic ft, b;
  int   x, y, ticks, bounces;
  int   y_hit;

  initial begin
    do_reset();
    check("rst_x", int'(x_pos), 400);
    check("rst_y", int'(y_pos), 300);
    check("rst_tick", int'(frame_tick), 0);
    check("rst_bounce", int'(bounce), 0);

    do_frame(ft, x, y, b);
    check("f1_tick", int'(ft), 1);
    check("f1_x", x, 402);
`ifdef BALL_Y_MOTION_EN
    check("f1_y", y, 302);
`else
    check("f1_y", y, 300);
`endif
    check("f1_bounce", int'(b), 0);

    do_reset();
    ticks = 0;
    bounces = 0;
    y_hit = 0;
    for (int k = 1; k <= 200; k++) begin
      do_frame(ft, x, y, b);
      ticks += int'(ft);
      bounces += int'(b);
      if (k == 190) check("f190_x", x, 780);
      if (k == 191) begin
        check("f191_x", x, 782);
        check("f191_bounce", int'(b), 1);
      end
      if (k == 192) begin
        check("f192_x", x, 780);
        check("f192_bounce", int'(b), 0);
      end
`ifdef BALL_Y_MOTION_EN
      if (k == 140) check("f140_y", y, 580);
      if (k == 141) begin
        check("f141_y", y, 582);
        check("f141_bounce", int'(b), 1);
      end
`else
      if (y != 300) y_hit++;
`endif
    end
    check("f200_x", x, 764);
    check("ticks_200", ticks, 200);
`ifdef BALL_Y_MOTION_EN
    check("bounces_200", bounces, 2);
`else
    check("y_moved", y_hit, 0);
    check("bounces_200", bounces, 1);
`endif

    do_reset();
    run = 1'b0;
    ticks = 0;
    bounces = 0;
    for (int k = 0; k < 3; k++) begin
      do_frame(ft, x, y, b);
      ticks += int'(ft);
      bounces += int'(b);
    end
    check("hold_ticks", ticks, 3);
    check("hold_x", x, 400);
    check("hold_y", y, 300);
    check("hold_bounce", bounces, 0);
    run = 1'b1;

    do_reset();
    @(negedge clk);
    v_count = 11'd599;
    @(negedge clk);
    v_count = 11'd600;
    @(negedge clk);
    v_count = 11'd0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_x", int'(x_pos), 400);
    check("midrst_y", int'(y_pos), 300);
    check("midrst_bounce", int'(bounce), 0);
    bounces = 0;
    repeat (4) begin
      @(negedge clk);
      bounces += int'(bounce);
    end
    check("midrst_nocommit_x", int'(x_pos), 400);
    check("midrst_nocommit_b", bounces, 0);
    do_frame(ft, x, y, b);
    check("midrst_next_x", x, 402);
`ifdef BALL_Y_MOTION_EN
    check("midrst_next_y", y, 302);
`else
    check("midrst_next_y", y, 300);
`endif

    do_reset();
    ticks = 0;
    @(negedge clk);
    v_count = 11'd0;
    @(negedge clk);
    v_count = 11'd600;
    repeat (20) begin
      @(negedge clk);
      ticks += int'(frame_tick);
    end
    check("jump_ticks", ticks, 0);
    check("jump_x", int'(x_pos), 400);
    v_count = 11'd599;
    @(negedge clk);
    v_count = 11'd600;
    ticks = 0;
    repeat (50) begin
      @(negedge clk);
      ticks += int'(frame_tick);
    end
    check("held600_ticks", ticks, 1);
    check("held600_x", int'(x_pos), 402);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ball_motion.md
# ball_motion

Per-frame object position generator that sits directly upstream of the pixel/frame renderer. It watches the raster counters, detects the start of vertical blanking once per frame, and advances a bouncing object's centre (`x_pos`, `y_pos`) inside the visible area. Positions change only during vertical blanking, so the renderer never draws a frame with a half-updated position.

## Interface
Parameters:
- `WIDTH`, default 800: visible pixels per line.
- `HEIGHT`, default 600: visible lines per frame.
- `RADIUS`, default 17: object radius in pixels; sets the bounce margin.
- `STEP`, default 2: pixels moved per axis per frame; legal range 1 to RADIUS.
- `X_INIT`, default 400: reset x centre.
- `Y_INIT`, default 300: reset y centre.

Ports:
- `clk`  in  1  pixel clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `h_count`  in  11  raster column from the timing generator.
- `v_count`  in  11  raster line from the timing generator.
- `run`  in  1  high = move each frame; low = hold position.
- `x_pos`  out  11  object centre x, feeds the renderer.
- `y_pos`  out  11  object centre y, feeds the renderer.
- `frame_tick`  out  1  one-cycle pulse per detected vblank start.
- `bounce`  out  1  one-cycle pulse when a wall reflection is committed.

## Operation
- Limits: `XMIN = RADIUS`, `XMAX = WIDTH-1-RADIUS`, `YMIN = RADIUS`, `YMAX = HEIGHT-1-RADIUS`.
- Direction registers: `dx` and `dy`, each 1 bit (1 = increasing).
- `v_prev` registers `v_count` every cycle.
- Vblank start is detected when `v_count == HEIGHT` and `v_prev == HEIGHT-1`. A `v_count` that jumps to HEIGHT from any other value is not a vblank start. `h_count` is unused for detection.
- FSM states:
  - WAIT: idle until vblank start is detected, then go to MOVE_X.
  - MOVE_X: compute the next x. Go to MOVE_Y.
  - MOVE_Y: compute the next y. Go to COMMIT.
  - COMMIT: load `x_pos`/`y_pos` from the computed values, pulse `bounce` if either axis flipped, then return to WAIT.
- Axis rule (x shown; y is identical):
  - If `dx=1` and `x+STEP >= XMAX`: next x = XMAX, `dx` flips to 0.
  - If `dx=0` and `x <= XMIN+STEP`: next x = XMIN, `dx` flips to 1.
  - Otherwise: next x = x ± STEP.
  - The down-going comparison is ordered so the subtraction never underflows. All arithmetic is 11-bit unsigned.
- `run` is sampled in MOVE_X. If it is low, the computed values equal the current values, no flip occurs and `bounce` stays 0. `frame_tick` still pulses.
- Reset values:
  - `x_pos = X_INIT`, `y_pos = Y_INIT`
  - `dx = dy = 1`
  - `frame_tick = 0`, `bounce = 0`
  - `v_prev = 0`
  - state = WAIT
- Reset asserted in any state discards the pending update; outputs take their reset values on the next edge.
- A vblank start detected while the FSM is not in WAIT is ignored. This cannot happen with legal timing.

## Timing
- Cycle 0: vblank start detected while in WAIT.
- Cycle 1: `frame_tick` high for exactly this one cycle; state is MOVE_X.
- Cycle 2: state is MOVE_Y.
- Cycle 3: state is COMMIT.
- Cycle 4: new `x_pos`/`y_pos` visible; `bounce` high for this one cycle if a flip occurred.
- Update latency is fixed at 4 cycles from detection, and both axes change on the same edge.
- Outputs are registered, with no combinational path from input to output.

## Configuration
- `BALL_Y_MOTION_EN` defined: y moves and bounces per the axis rule.
- `BALL_Y_MOTION_EN` undefined:
  - `y_pos` is held at Y_INIT permanently and `dy` is removed.
  - The MOVE_Y state is still traversed, so latency stays at 4 cycles.
  - `bounce` reflects x flips only.

## Structure
- Package `ball_pkg` holds:
  - the state enum `ball_state_t` (WAIT, MOVE_X, MOVE_Y, COMMIT);
  - the 11-bit coordinate typedef `coord_t`;
  - the default geometry constants.
- Sub-module `vblank_detect` contains the `v_prev` register, the compare logic and the `frame_tick` register. It outputs the cycle-0 detect strobe to the FSM.

## Test plan
- Reset, then one vblank start (`v_count` 599 → 600), defaults: `frame_tick` high in cycle 1; `x_pos=402`, `y_pos=302` in cycle 4; `bounce=0`.
- 191 consecutive frames from reset: frame 191 commits `x_pos=782` with `bounce=1`; frame 192 gives `x_pos=780`. With the macro, `y_pos` reaches 582 at frame 141 with `bounce=1`.
- `run=0` across 3 frames: `frame_tick` pulses 3 times; `x_pos`/`y_pos` stay at 400/300; `bounce` stays 0.
- `rst` asserted during MOVE_Y of frame 1: the next cycle shows `x_pos=400`, `y_pos=300`, no commit, `bounce=0`; the following vblank start produces a normal update to 402/302.
- `v_count` forced from 0 straight to 600, and `v_count` held at 600 for many cycles: no `frame_tick`, and at most one tick per genuine 599 → 600 transition.
- Macro undefined, 200 frames: `y_pos` stays at 300 throughout; `x_pos` bounce behaviour is unchanged.
